// File: rtl/add_pkg.sv
// Shared definitions for the add/sub arbiter: flag bit positions, FSM encoding, datapath width.
package add_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_e;

  // Distance of requester i after the round-robin pointer (0 = first in line).
  function automatic int unsigned rr_dist(input int unsigned i, input int unsigned ptr,
                                          input int unsigned n);
    return (i + n - ptr - 1) % n;
  endfunction

endpackage

// File: rtl/add_arbiter_add.sv
// Shared 32-bit ADD/SUB unit producing Result and the NZCV flags of the operation.
module ADD
  import add_pkg::*;
(
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             S,
  input  logic [3:0]       Flag,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       New_Flag
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff;
  logic [3:0]       unused_flag;

  // Subtraction is In1 + ~In2 + 1, so C=1 means no borrow.
  always_comb begin
    b_eff  = S ? ~In2 : In2;
    sum    = {1'b0, In1} + {1'b0, b_eff} + (WIDTH+1)'(S);
    Result = sum[WIDTH-1:0];
    New_Flag         = 4'b0000;
    New_Flag[FLAG_N] = sum[WIDTH-1];
    New_Flag[FLAG_Z] = (sum[WIDTH-1:0] == '0);
    New_Flag[FLAG_C] = sum[WIDTH];
    New_Flag[FLAG_V] = (In1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != In1[WIDTH-1]);
  end

  assign unused_flag = Flag;

endmodule

// File: rtl/add_arbiter_rr_arbiter.sv
// Round-robin picker: first valid requester after the pointer, wrapping.
module rr_arbiter
  import add_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [PW-1:0]   grant_idx,
  output logic            any_valid
);

  int unsigned best_d;

  always_comb begin
    best_d    = NREQ;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (valid[i] && (rr_dist(i, int'(ptr), NREQ) < best_d)) begin
        best_d    = rr_dist(i, int'(ptr), NREQ);
        grant_idx = PW'(i);
        any_valid = 1'b1;
      end
    end
    grant_oh = any_valid ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates NREQ requesters onto one shared ADD unit and owns the NZCV flag register.
module add_arbiter
  import add_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  input  logic [NREQ-1:0]       req_setf,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [3:0]            flags_q,
  output logic                  busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [3:0]        flg_q, flg_d;

  logic [NREQ-1:0]   grant_oh;
  logic [PW-1:0]     grant_idx;
  logic              any_valid;
  logic [WIDTH-1:0]  a_mux, b_mux, add_result;
  logic              sub_mux, setf_mux;
  logic [3:0]        new_flag;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Operand mux from the granted requester's slice.
  always_comb begin
    a_mux    = '0;
    b_mux    = '0;
    sub_mux  = 1'b0;
    setf_mux = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        a_mux    = req_a[i*WIDTH +: WIDTH];
        b_mux    = req_b[i*WIDTH +: WIDTH];
        sub_mux  = req_sub[i];
        setf_mux = req_setf[i];
      end
    end
  end

  ADD u_add (
    .In1      (a_mux),
    .In2      (b_mux),
    .S        (sub_mux),
    .Flag     (flg_q),
    .Result   (add_result),
    .New_Flag (new_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_RSP;
      ST_RSP:  if (rsp_ready[gnt_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    flg_d        = flg_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready    = grant_oh;
          rr_d         = grant_idx;
          gnt_d        = grant_idx;
          rsp_valid_d  = grant_oh;
          rsp_result_d = add_result;
          rsp_flags_d  = new_flag;
          if (setf_mux) flg_d = new_flag;
        end
      end
      ST_RSP: begin
        if (rsp_ready[gnt_q]) rsp_valid_d = '0;
      end
      default: ;
    endcase
  end

  // Pointer resets to the last requester so requester 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= PW'(NREQ - 1);
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      flg_q        <= '0;
    end else begin
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      flg_q        <= flg_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign flags_q    = flg_q;
  assign busy       = (state_q == ST_RSP);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed plus randomized checks of add_arbiter against an arithmetic reference model.
module tb_add_arbiter;

  localparam int unsigned NREQ = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready, req_sub, req_setf;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]    rsp_valid, rsp_ready;
  logic [31:0]        rsp_result;
  logic [3:0]         rsp_flags, flags_q;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int last_g;
  logic [3:0] mflags;

  add_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .req_setf   (req_setf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .flags_q    (flags_q),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {N,Z,C,V, result} from plain 64-bit arithmetic.
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
    longint unsigned ua, ub;
    longint sa, sb, rs;
    logic [63:0] ru;
    logic [31:0] r;
    logic n, z, c, v;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ru = sub ? (ua - ub) : (ua + ub);
    r  = ru[31:0];
    rs = sub ? (sa - sb) : (sa + sb);
    n  = r[31];
    z  = (r == 32'd0);
    c  = sub ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    v  = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    return {n, z, c, v, r};
  endfunction

  function automatic int next_grant(input logic [NREQ-1:0] v);
    for (int off = 1; off <= int'(NREQ); off++) begin
      if (v[(last_g + off) % NREQ]) return (last_g + off) % NREQ;
    end
    return -1;
  endfunction

  // Single op on one requester; response held `hold` cycles before consumption.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic setf, input int hold);
    logic [35:0] exp;
    int g;
    int waited;
    waited = 0;
    while (busy !== 1'b0 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_sub[idx]  = sub;
    req_setf[idx] = setf;
    #1;
    g = next_grant(req_valid);
    check("req_ready", 32'(req_ready), 32'(1) << g);
    exp = ref_op(a, b, sub);
    @(posedge clk); #1;
    req_valid = '0;
    last_g = g;
    if (setf) mflags = exp[35:32];
    check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    check("rsp_result", rsp_result, exp[31:0]);
    check("rsp_flags", 32'(rsp_flags), 32'(exp[35:32]));
    check("flags_q", 32'(flags_q), 32'(mflags));
    check("busy", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = '0;
      rsp_ready[1-idx] = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'(1) << g);
      check("hold_result", rsp_result, exp[31:0]);
      check("hold_flags", 32'(rsp_flags), 32'(exp[35:32]));
    end
    rsp_ready = '0;
    rsp_ready[idx] = 1'b1;
    @(posedge clk); #1;
    rsp_ready = '0;
    check("consumed", 32'(rsp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Both requesters valid with fresh random operands; always ready for responses.
  task automatic contend_step();
    logic [31:0] a_r [NREQ];
    logic [31:0] b_r [NREQ];
    logic [35:0] exp;
    int g;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_r[i] = $urandom;
      b_r[i] = ($urandom_range(0, 3) == 0) ? a_r[i] : $urandom;
      req_a[i*32 +: 32] = a_r[i];
      req_b[i*32 +: 32] = b_r[i];
      req_sub[i]  = 1'($urandom_range(0, 1));
      req_setf[i] = 1'($urandom_range(0, 1));
    end
    req_valid = '1;
    rsp_ready = '1;
    #1;
    g = next_grant(req_valid);
    check("rr_ready", 32'(req_ready), 32'(1) << g);
    exp = ref_op(a_r[g], b_r[g], req_sub[g]);
    if (req_setf[g]) mflags = exp[35:32];
    @(posedge clk); #1;
    last_g = g;
    check("rr_rsp_valid", 32'(rsp_valid), 32'(1) << g);
    check("rr_result", rsp_result, exp[31:0]);
    check("rr_flags", 32'(rsp_flags), 32'(exp[35:32]));
    check("rr_flags_q", 32'(flags_q), 32'(mflags));
    check("rr_no_ready_in_rsp", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rr_consumed", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    rsp_ready = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; req_setf = '0; rsp_ready = '0;
    last_g = int'(NREQ) - 1;
    mflags = 4'b0000;
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1..T3 directed arithmetic
    do_op(0, 32'd2, 32'd3, 1'b0, 1'b1, 0);
    check("t1_flags", 32'(flags_q), 32'h0);
    do_op(1, 32'd1, 32'd3, 1'b1, 1'b1, 0);
    check("t2_flags", 32'(flags_q), 32'h8);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1);
    check("t3a_flags", 32'(flags_q), 32'h6);
    do_op(1, 32'd4, 32'd4, 1'b1, 1'b1, 0);
    check("t3b_flags", 32'(flags_q), 32'h6);

    // T5 no flag update, long hold with other line's rsp_ready toggled
    do_op(0, 32'd10, 32'd10, 1'b0, 1'b0, 5);
    check("t5_flags_kept", 32'(flags_q), 32'h6);

    // T4 contention
    for (int k = 0; k < 10; k++) contend_step();

    // Randomized single-requester traffic
    for (int k = 0; k < 24; k++) begin
      do_op($urandom_range(0, 1), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    do_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 0);
    check("ovf_add_flags", 32'(flags_q), 32'h9);
    do_op(1, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 0);
    check("ovf_sub_flags", 32'(flags_q), 32'h3);

    // T6 reset while a response is pending
    req_valid = 2'b10;
    req_a[63:32] = 32'd1; req_b[63:32] = 32'd2; req_sub[1] = 1'b1; req_setf[1] = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_flags_set", 32'(flags_q), 32'h8);
    rst = 1'b1;
    #2;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_flags_q", 32'(flags_q), 32'd0);
    check("t6_busy_clr", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = int'(NREQ) - 1;
    mflags = 4'b0000;
    contend_step();
    check("t6_first_grant", 32'(last_g), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
